// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - CPU-side load/store initiator for a single-port RAM with registered read address
//
// Accepts one load or store at a time. The address is held in MAR and the data in MDR.
// The controller drives the RAM strobes and captures read data into MDR.
// Each request gets a one-cycle response pulse.
//
// Ports
//   clock, reset      : single clock; synchronous active-high reset
//   req_valid/ready   : request handshake (ready only while idle and not in reset)
//   req_write         : 1 = store, 0 = load
//   req_addr          : word address
//   req_wdata         : store data
//   resp_valid        : one-cycle completion pulse
//   resp_err          : out-of-range address, qualified by resp_valid
//   resp_rdata        : MDR contents
//   busy              : inverse of req_ready
//   mem_addr          : RAM addr, driven from MAR
//   mem_data          : RAM data, driven from MDR
//   mem_write         : RAM write strobe
//   mem_read          : RAM read strobe
//   mem_q             : RAM read data
module ram_access_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_mar;
    logic [DATA_W-1:0]   r_mdr;
    logic                r_write;
    logic                r_err;

    logic                w_idle;
    logic                w_accept;
    logic                w_addr_err;
    logic                w_mem_write;
    logic                w_mem_read;

    // Range check is done on the zero-extended address so that DEPTH values
    // at or above 2**ADDR_W simply never flag an error.
    assign w_addr_err = (32'(req_addr) >= 32'(DEPTH));

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle && req_valid && !reset;

    always_comb begin
        w_next      = r_state;
        w_mem_write = 1'b0;
        w_mem_read  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    // Out-of-range requests skip the RAM entirely.
                    w_next = w_addr_err ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_mem_write = r_write;
                w_mem_read  = !r_write;
                w_next      = r_write ? S_RESP : S_CAPTURE;
            end
            S_CAPTURE: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mar   <= '0;
            r_mdr   <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_mar   <= req_addr;
                r_write <= req_write;
                r_err   <= w_addr_err;
                // Loads leave MDR alone so an errored load reports the previous value.
                if (req_write) begin
                    r_mdr <= req_wdata;
                end
            end else if (r_state == S_CAPTURE) begin
                // RAM latched the address at the ISSUE edge, so q is valid now.
                r_mdr <= mem_q;
            end
        end
    end

    // Strobes and ready are gated by reset so that nothing happens at a reset edge.
    assign mem_write  = w_mem_write && !reset;
    assign mem_read   = w_mem_read && !reset;
    assign req_ready  = w_idle && !reset;
    assign busy       = !req_ready;
    assign resp_valid = (r_state == S_RESP);
    assign resp_err   = resp_valid && r_err;
    assign resp_rdata = r_mdr;
    assign mem_addr   = r_mar;
    assign mem_data   = r_mdr;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - self-checking bench for ram_access_ctrl (DEPTH 512 and DEPTH 256 instances)
module tb_ram_access_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [1:0]  reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_err;
    logic [1:0]  busy;
    logic [1:0]  mem_write;
    logic [1:0]  mem_read;
    logic [8:0]  req_addr   [2];
    logic [8:0]  mem_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [31:0] resp_rdata [2];
    logic [31:0] mem_data   [2];
    logic [31:0] mem_q      [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE0000 | 32'(i);
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int DEPTH = (g == 0) ? 512 : 256;

        ram_access_ctrl #(.ADDR_W(9), .DATA_W(32), .DEPTH(DEPTH)) dut (
            .clock      (clock),
            .reset      (reset[g]),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_write  (req_write[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .resp_valid (resp_valid[g]),
            .resp_err   (resp_err[g]),
            .resp_rdata (resp_rdata[g]),
            .busy       (busy[g]),
            .mem_addr   (mem_addr[g]),
            .mem_data   (mem_data[g]),
            .mem_write  (mem_write[g]),
            .mem_read   (mem_read[g]),
            .mem_q      (mem_q[g])
        );

        // The RAM device: write at the edge, registered read address.
        logic [31:0] ram     [512];
        logic [31:0] ref_mem [512];
        logic [8:0]  ram_ra;
        initial begin
            for (int i = 0; i < 512; i++) begin
                ram[i]     = init_word(i);
                ref_mem[i] = init_word(i);
            end
            ram_ra = '0;
        end
        always @(posedge clock) begin
            if (mem_write[g]) ram[mem_addr[g]] = mem_data[g];
            if (mem_read[g])  ram_ra = mem_addr[g];
        end
        assign mem_q[g] = ram[ram_ra];

        // Transaction-level reference: one request in flight, response after a fixed latency.
        bit          m_busy = 1'b0;
        int          m_phase = 0;
        int          m_rphase = 0;
        bit          m_write = 1'b0;
        bit          m_err = 1'b0;
        logic [8:0]  m_mar = '0;
        logic [31:0] m_mdr = '0;
        logic [31:0] m_exp = '0;

        always @(posedge clock) begin
            if (reset[g]) begin
                m_busy = 1'b0;
                m_mar  = '0;
                m_mdr  = '0;
                m_err  = 1'b0;
            end else if (!m_busy) begin
                if (req_valid[g]) begin
                    m_busy   = 1'b1;
                    m_phase  = 0;
                    m_write  = req_write[g];
                    m_mar    = req_addr[g];
                    m_err    = (int'(req_addr[g]) >= DEPTH);
                    m_rphase = m_err ? 0 : (m_write ? 1 : 2);
                    if (m_write) m_mdr = req_wdata[g];
                    m_exp = m_write ? req_wdata[g] : (m_err ? m_mdr : ref_mem[req_addr[g]]);
                end
            end else begin
                if (m_phase == 0 && m_write && !m_err) ref_mem[m_mar] = m_mdr;
                m_phase++;
                if (m_phase == m_rphase) m_mdr = m_exp;
                if (m_phase > m_rphase) m_busy = 1'b0;
            end
        end

        int n_rd = 0;
        int n_wr = 0;
        bit e_rv, e_acc;

        always @(negedge clock) begin
            if (mem_read[g])  n_rd++;
            if (mem_write[g]) n_wr++;
            if (chk_en) begin
                e_rv  = m_busy && (m_phase == m_rphase);
                e_acc = !reset[g] && m_busy && (m_phase == 0) && !m_err;
                chk1($sformatf("i%0d req_ready", g), req_ready[g], !reset[g] && !m_busy);
                chk1($sformatf("i%0d busy", g), busy[g], reset[g] || m_busy);
                chk1($sformatf("i%0d resp_valid", g), resp_valid[g], e_rv);
                chk1($sformatf("i%0d resp_err", g), resp_err[g], e_rv && m_err);
                chk1($sformatf("i%0d mem_write", g), mem_write[g], e_acc && m_write);
                chk1($sformatf("i%0d mem_read", g), mem_read[g], e_acc && !m_write);
                chk32($sformatf("i%0d mem_addr", g), 32'(mem_addr[g]), 32'(m_mar));
                chk32($sformatf("i%0d mem_data", g), mem_data[g], m_mdr);
                chk32($sformatf("i%0d resp_rdata", g), resp_rdata[g], m_mdr);
            end
        end
    end

    task automatic do_req(input int g, input bit w, input logic [8:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er);
        int n;
        req_valid[g] = 1'b1;
        req_write[g] = w;
        req_addr[g]  = a;
        req_wdata[g] = d;
        lat = -1;
        rd  = 'x;
        er  = 1'bx;
        n   = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!req_ready[g] && n < 20);
        chk1("accept within bound", req_ready[g], 1'b1);
        @(posedge clock);
        #1;
        req_valid[g] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            // Inputs wander while busy; the controller must ignore them.
            req_addr[g]  = 9'($urandom);
            req_wdata[g] = $urandom;
            req_write[g] = 1'($urandom);
            @(negedge clock);
            if (resp_valid[g]) begin
                lat = k;
                rd  = resp_rdata[g];
                er  = resp_err[g];
                break;
            end
        end
        chk1("response within bound", lat > 0, 1'b1);
    endtask

    logic [8:0] b2b_addr [3];
    int         lat;
    logic [31:0] rd;
    logic        er;
    int          base_rd, base_wr;
    int          sent, got, n;
    int          resp_cyc [3];
    logic [31:0] resp_dat [3];

    initial begin
        b2b_addr[0] = 9'h000;
        b2b_addr[1] = 9'h001;
        b2b_addr[2] = 9'h1FF;
        reset     = 2'b11;
        req_valid = 2'b00;
        req_write = 2'b00;
        for (int g = 0; g < 2; g++) begin
            req_addr[g]  = '0;
            req_wdata[g] = '0;
        end
        repeat (2) @(posedge clock);
        chk_en = 1'b1;
        @(posedge clock);
        #1;
        reset = 2'b00;

        // Reset state.
        @(negedge clock);
        chk1("reset req_ready", req_ready[0], 1'b1);
        chk1("reset busy", busy[0], 1'b0);
        chk32("reset mem_addr", 32'(mem_addr[0]), 32'h0);
        chk32("reset resp_rdata", resp_rdata[0], 32'h0);

        // Back-to-back loads with req_valid held high.
        base_rd = inst[0].n_rd;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = b2b_addr[0];
        sent = 0;
        got  = 0;
        n    = 0;
        while (got < 3 && n < 40) begin
            if (n > 0) @(negedge clock);
            n++;
            if (resp_valid[0]) begin
                resp_cyc[got] = cyc;
                resp_dat[got] = resp_rdata[0];
                got++;
            end
            if (req_ready[0] && sent < 3) begin
                @(posedge clock);
                #1;
                sent++;
                if (sent < 3) req_addr[0] = b2b_addr[sent];
                else req_valid[0] = 1'b0;
            end
        end
        req_valid[0] = 1'b0;
        chk32("b2b response count", 32'(got), 32'd3);
        chk32("b2b word 0", resp_dat[0], 32'hC0DE0000);
        chk32("b2b word 1", resp_dat[1], 32'hC0DE0001);
        chk32("b2b word 2", resp_dat[2], 32'hC0DE01FF);
        chk32("b2b spacing 0-1", 32'(resp_cyc[1] - resp_cyc[0]), 32'd4);
        chk32("b2b spacing 1-2", 32'(resp_cyc[2] - resp_cyc[1]), 32'd4);
        chk32("b2b read strobes", 32'(inst[0].n_rd - base_rd), 32'd3);

        // Store then load.
        base_wr = inst[0].n_wr;
        do_req(0, 1'b1, 9'h005, 32'hDEADBEEF, lat, rd, er);
        chk32("store latency", 32'(lat), 32'd2);
        chk1("store err", er, 1'b0);
        chk32("store rdata", rd, 32'hDEADBEEF);
        chk32("store write strobes", 32'(inst[0].n_wr - base_wr), 32'd1);
        do_req(0, 1'b0, 9'h005, 32'h0, lat, rd, er);
        chk32("load latency", 32'(lat), 32'd3);
        chk1("load err", er, 1'b0);
        chk32("load after store", rd, 32'hDEADBEEF);

        // Wrap boundary.
        do_req(0, 1'b1, 9'h1FF, 32'hA5A5A5A5, lat, rd, er);
        do_req(0, 1'b1, 9'h000, 32'h5A5A5A5A, lat, rd, er);
        do_req(0, 1'b0, 9'h1FF, 32'h0, lat, rd, er);
        chk32("wrap load 1FF", rd, 32'hA5A5A5A5);
        chk1("wrap err 1FF", er, 1'b0);
        do_req(0, 1'b0, 9'h000, 32'h0, lat, rd, er);
        chk32("wrap load 000", rd, 32'h5A5A5A5A);

        // Reset during ISSUE of a store.
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 9'h010;
        req_wdata[0] = 32'h12345678;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!req_ready[0] && n < 20);
        @(posedge clock);
        #1;
        req_valid[0] = 1'b0;
        reset[0] = 1'b1;
        @(negedge clock);
        chk1("reset-in-issue mem_write", mem_write[0], 1'b0);
        chk1("reset-in-issue resp_valid", resp_valid[0], 1'b0);
        @(posedge clock);
        #1;
        reset[0] = 1'b0;
        @(negedge clock);
        chk32("post-reset MAR", 32'(mem_addr[0]), 32'h0);
        chk32("post-reset MDR", mem_data[0], 32'h0);
        chk1("post-reset resp_valid", resp_valid[0], 1'b0);
        do_req(0, 1'b0, 9'h010, 32'h0, lat, rd, er);
        chk32("dropped store not written", rd, 32'hC0DE0010);

        // Out of range on the DEPTH=256 instance.
        base_rd = inst[1].n_rd;
        base_wr = inst[1].n_wr;
        do_req(1, 1'b0, 9'h100, 32'h0, lat, rd, er);
        chk32("oor load latency", 32'(lat), 32'd1);
        chk1("oor load err", er, 1'b1);
        do_req(1, 1'b1, 9'h1A0, 32'hFEEDF00D, lat, rd, er);
        chk32("oor store latency", 32'(lat), 32'd1);
        chk1("oor store err", er, 1'b1);
        chk32("oor store rdata", rd, 32'hFEEDF00D);
        chk32("oor no reads", 32'(inst[1].n_rd - base_rd), 32'd0);
        chk32("oor no writes", 32'(inst[1].n_wr - base_wr), 32'd0);
        do_req(1, 1'b0, 9'h0FF, 32'h0, lat, rd, er);
        chk32("in-range load after oor", rd, 32'hC0DE00FF);
        chk1("in-range err after oor", er, 1'b0);

        // Randomized traffic on both instances, checked by the reference model.
        repeat (3000) begin
            @(posedge clock);
            #1;
            for (int g = 0; g < 2; g++) begin
                reset[g]     = ($urandom_range(0, 63) == 0);
                req_valid[g] = ($urandom_range(0, 2) != 0);
                req_write[g] = 1'($urandom);
                req_addr[g]  = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 7));
                req_wdata[g] = $urandom;
            end
        end
        @(posedge clock);
        #1;
        reset     = 2'b00;
        req_valid = 2'b00;
        repeat (10) @(posedge clock);
        @(negedge clock);
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
